if_fetch_unit: RTL

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It drives `o_IF_current_pc` into the next-PC selector and consumes the selector's `i_next_pc` whenever an instruction is handed to ID or a kill redirect occurs. It runs a req/ack handshake to instruction memory with variable latency and buffers a fetched word while ID is stalled. When a redirect arrives, it discards any in-flight fetch.

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit holds req and addr steady until ack. The memory may ack in
// the same cycle as the request (zero-wait) or after any number of waits.
interface if_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   // Fetch unit side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   // Instruction memory side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It owns the program counter and the IF/ID pipeline
// register, and it fetches from instruction memory over a req/ack bus with
// variable latency.
//
// The FSM has three states:
//   FETCH   - Requests the word at pc. A misaligned pc completes at once with
//             adel set and no bus request.
//   HOLD    - A completed fetch is parked in the hold buffer while ID stalls.
//   DISCARD - A redirect arrived while a request was outstanding. The bus
//             request is kept alive until its ack, and the returned data is
//             dropped.
//
// The next-PC selector is sampled only at hand-off, so a branch delay slot is
// always fetched and delivered without any help from this block.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   // Next-PC selector
   input  logic [31:0]            i_next_pc,
   input  logic                   i_redirect,
   input  logic                   i_stall,
   output logic [31:0]            o_IF_current_pc,
   // Instruction memory bus
   if_fetch_unit_if.master        imem,
   // IF/ID pipeline register
   output logic                   o_ID_valid,
   output logic [31:0]            o_ID_instr,
   output logic [31:0]            o_ID_pc,
   output logic                   o_ID_adel
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   // Registered state
   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] discard_addr_q;

   logic [31:0] buf_instr_q;
   logic [31:0] buf_pc_q;
   logic        buf_adel_q;
   logic        buf_full_q;

   logic        id_valid_q;
   logic [31:0] id_instr_q;
   logic [31:0] id_pc_q;
   logic        id_adel_q;

   // Fetch result for the current cycle
   logic        pc_aligned_d;
   logic        fetch_done_d;
   logic [31:0] fetch_instr_d;
   logic        fetch_adel_d;

   // A misaligned pc never goes onto the bus. It completes immediately as an
   // address-error pseudo-instruction with a zero instruction word.
   assign pc_aligned_d  = (pc_q[1:0] == 2'b00);
   assign fetch_done_d  = (state_q == S_FETCH) && (!pc_aligned_d || imem.imem_ack);
   assign fetch_instr_d = pc_aligned_d ? imem.imem_rdata : 32'h0000_0000;
   assign fetch_adel_d  = !pc_aligned_d;

   // Bus request is decoded from registered state only. Reset masks it, so
   // req stays low during the reset cycle whatever the prior state was.
   always_comb begin
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      case (state_q)
         S_FETCH: begin
            imem.imem_req  = pc_aligned_d;
            imem.imem_addr = pc_q;
         end
         S_DISCARD: begin
            imem.imem_req  = 1'b1;
            imem.imem_addr = discard_addr_q;
         end
         default: begin
            imem.imem_req  = 1'b0;
            imem.imem_addr = pc_q;
         end
      endcase
      if (i_rst) begin
         imem.imem_req = 1'b0;
      end
   end

   // Fetch FSM, PC, hold buffer and IF/ID register.
   // Priority order: reset, then redirect, then normal operation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q        <= S_FETCH;
         pc_q           <= RESET_PC;
         discard_addr_q <= 32'h0000_0000;
         buf_instr_q    <= 32'h0000_0000;
         buf_pc_q       <= 32'h0000_0000;
         buf_adel_q     <= 1'b0;
         buf_full_q     <= 1'b0;
         id_valid_q     <= 1'b0;
         id_instr_q     <= 32'h0000_0000;
         id_pc_q        <= 32'h0000_0000;
         id_adel_q      <= 1'b0;
      end else if (i_redirect) begin
         // A kill redirect flushes every IF-side instruction. It overrides
         // both the stall and any completion in this cycle.
         pc_q       <= i_next_pc;
         id_valid_q <= 1'b0;
         buf_full_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               // An unacked request must still be seen through on the bus.
               // An acked or misaligned fetch is simply dropped.
               if (pc_aligned_d && !imem.imem_ack) begin
                  discard_addr_q <= pc_q;
                  state_q        <= S_DISCARD;
               end
            end
            S_HOLD: begin
               state_q <= S_FETCH;
            end
            S_DISCARD: begin
               // The outstanding request is unchanged. Only pc moves.
               if (imem.imem_ack) begin
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            S_FETCH: begin
               if (fetch_done_d) begin
                  if (!i_stall) begin
                     // Hand the fetched word straight to ID.
                     id_valid_q <= 1'b1;
                     id_instr_q <= fetch_instr_d;
                     id_pc_q    <= pc_q;
                     id_adel_q  <= fetch_adel_d;
                     pc_q       <= i_next_pc;
                  end else begin
                     // ID is busy, so park the word. IF/ID keeps its value.
                     buf_instr_q <= fetch_instr_d;
                     buf_pc_q    <= pc_q;
                     buf_adel_q  <= fetch_adel_d;
                     buf_full_q  <= 1'b1;
                     state_q     <= S_HOLD;
                  end
               end else if (!i_stall) begin
                  id_valid_q <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!i_stall) begin
                  id_valid_q <= buf_full_q;
                  id_instr_q <= buf_instr_q;
                  id_pc_q    <= buf_pc_q;
                  id_adel_q  <= buf_adel_q;
                  pc_q       <= i_next_pc;
                  buf_full_q <= 1'b0;
                  state_q    <= S_FETCH;
               end
            end
            S_DISCARD: begin
               // Nothing is handed off here. The stall only decides whether
               // ID sees a bubble or keeps what it has.
               if (!i_stall) begin
                  id_valid_q <= 1'b0;
               end
               if (imem.imem_ack) begin
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   assign o_IF_current_pc = pc_q;
   assign o_ID_valid      = id_valid_q;
   assign o_ID_instr      = id_instr_q;
   assign o_ID_pc         = id_pc_q;
   assign o_ID_adel       = id_adel_q;

endmodule
